// File: rtl/psum_sram_sequencer.sv
// Partial-sum SRAM sequencer: zero-init a row range, run P read passes over it,
// drain the systolic skew, then sweep the finished sums out. All outputs registered.
//
// state  | meaning
// IDLE   | waiting for i_Start
// INIT   | writing zero to rows 0..N-1
// RUN    | reading rows for accumulation, one row per cycle
// GAP    | one bubble between passes when N==1 (read-after-write on the same row)
// DRAIN  | PE_COL+1 idle cycles for loader skew and SRAM latency
// WB     | reading the finished rows out
// DONE   | one-cycle completion pulse
module psum_sram_sequencer #(
    parameter int BIT_ADDR = 8,
    parameter int PE_COL   = 4
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                i_Start,
    input  logic                i_Init_En,
    input  logic [BIT_ADDR-1:0] i_Num_Rows,
    input  logic [7:0]          i_Num_Passes,
    input  logic                i_Stall,
    output logic [BIT_ADDR-1:0] o_Psram_Addr,
    output logic [BIT_ADDR-1:0] o_Psram_Addr_1buf,
    output logic [PE_COL-1:0]   o_Psram_Valid_1buf,
    output logic [PE_COL-1:0]   o_Psram_En,
    output logic [PE_COL-1:0]   o_Psram_Wea,
    output logic                o_Valid_WB_Psum,
    output logic                o_WB_Data_Valid,
    output logic                o_Busy,
    output logic                o_Done
);

    localparam int DW = $clog2(PE_COL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_GAP,
        S_DRAIN,
        S_WB,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BIT_ADDR-1:0] rows_q, rows_d;
    logic [7:0]          passes_q, passes_d;
    logic [BIT_ADDR-1:0] r_q, r_d;
    logic [7:0]          p_q, p_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic [BIT_ADDR-1:0] addr_q, addr_d;
    logic [BIT_ADDR-1:0] addr_1buf_q, addr_1buf_d;
    logic                en_q, en_d;
    logic                wea_q, wea_d;
    logic                run_rd_q, run_rd_d;
    logic                valid_1buf_q, valid_1buf_d;
    logic                wb_rd_q, wb_rd_d;
    logic                wb_dv_q, wb_dv_d;
    logic                valid_wb_q, valid_wb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                last_row;
    logic                last_pass;

    assign last_row  = (r_q == rows_q - BIT_ADDR'(1));
    assign last_pass = (p_q == passes_q - 8'd1);

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        passes_d = passes_q;
        r_d      = r_q;
        p_d      = p_q;
        drain_d  = drain_q;
        addr_d   = '0;
        en_d     = 1'b0;
        wea_d    = 1'b0;
        run_rd_d = 1'b0;
        wb_rd_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    rows_d   = i_Num_Rows;
                    passes_d = i_Num_Passes;
                    r_d      = '0;
                    p_d      = '0;
                    if (i_Num_Rows == '0 || i_Num_Passes == '0) begin
                        state_d = S_DONE;
                    end else if (i_Init_En) begin
                        state_d = S_INIT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_INIT: begin
                addr_d = r_q;
                en_d   = 1'b1;
                wea_d  = 1'b1;
                if (last_row) begin
                    r_d     = '0;
                    state_d = S_RUN;
                end else begin
                    r_d = r_q + BIT_ADDR'(1);
                end
            end
            S_RUN: begin
                if (!i_Stall) begin
                    addr_d   = r_q;
                    en_d     = 1'b1;
                    run_rd_d = 1'b1;
                    if (last_row) begin
                        r_d = '0;
                        p_d = p_q + 8'd1;
                        if (last_pass) begin
                            drain_d = DW'(PE_COL);
                            state_d = S_DRAIN;
                        end else if (rows_q == BIT_ADDR'(1)) begin
                            state_d = S_GAP;
                        end
                    end else begin
                        r_d = r_q + BIT_ADDR'(1);
                    end
                end
            end
            S_GAP: begin
                state_d = S_RUN;
            end
            S_DRAIN: begin
                // down-counter loaded with PE_COL gives PE_COL+1 idle cycles
                if (drain_q == '0) begin
                    r_d     = '0;
                    state_d = S_WB;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_WB: begin
                if (!i_Stall) begin
                    addr_d  = r_q;
                    en_d    = 1'b1;
                    wb_rd_d = 1'b1;
                    if (last_row) begin
                        state_d = S_DONE;
                    end else begin
                        r_d = r_q + BIT_ADDR'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // write-back side trails the registered read address by one cycle
        valid_1buf_d = run_rd_q;
        addr_1buf_d  = run_rd_q ? addr_q : addr_1buf_q;
        wb_dv_d      = wb_rd_q;
        valid_wb_d   = (state_q == S_WB);
        busy_d       = (state_q != S_IDLE);
        done_d       = (state_q == S_DONE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= S_IDLE;
            rows_q       <= '0;
            passes_q     <= '0;
            r_q          <= '0;
            p_q          <= '0;
            drain_q      <= '0;
            addr_q       <= '0;
            addr_1buf_q  <= '0;
            en_q         <= 1'b0;
            wea_q        <= 1'b0;
            run_rd_q     <= 1'b0;
            valid_1buf_q <= 1'b0;
            wb_rd_q      <= 1'b0;
            wb_dv_q      <= 1'b0;
            valid_wb_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            passes_q     <= passes_d;
            r_q          <= r_d;
            p_q          <= p_d;
            drain_q      <= drain_d;
            addr_q       <= addr_d;
            addr_1buf_q  <= addr_1buf_d;
            en_q         <= en_d;
            wea_q        <= wea_d;
            run_rd_q     <= run_rd_d;
            valid_1buf_q <= valid_1buf_d;
            wb_rd_q      <= wb_rd_d;
            wb_dv_q      <= wb_dv_d;
            valid_wb_q   <= valid_wb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_Psram_Addr       = addr_q;
    assign o_Psram_Addr_1buf  = addr_1buf_q;
    assign o_Psram_Valid_1buf = {PE_COL{valid_1buf_q}};
    assign o_Psram_En         = {PE_COL{en_q}};
    assign o_Psram_Wea        = {PE_COL{wea_q}};
    assign o_Valid_WB_Psum    = valid_wb_q;
    assign o_WB_Data_Valid    = wb_dv_q;
    assign o_Busy             = busy_q;
    assign o_Done             = done_q;

endmodule

// File: tb/tb_psum_sram_sequencer.sv
// Scoreboard bench for psum_sram_sequencer: a loop-level model queues the expected
// issue stream per job; a negedge monitor pops and compares as the DUT presents it.
module tb_psum_sram_sequencer;

    localparam int BA = 8;
    localparam int PC = 4;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          i_Start = 1'b0;
    logic          i_Init_En = 1'b0;
    logic [BA-1:0] i_Num_Rows = '0;
    logic [7:0]    i_Num_Passes = '0;
    logic          i_Stall = 1'b0;
    logic [BA-1:0] o_Psram_Addr;
    logic [BA-1:0] o_Psram_Addr_1buf;
    logic [PC-1:0] o_Psram_Valid_1buf;
    logic [PC-1:0] o_Psram_En;
    logic [PC-1:0] o_Psram_Wea;
    logic          o_Valid_WB_Psum;
    logic          o_WB_Data_Valid;
    logic          o_Busy;
    logic          o_Done;

    psum_sram_sequencer #(.BIT_ADDR(BA), .PE_COL(PC)) dut (
        .CLK               (CLK),
        .RSTN              (RSTN),
        .i_Start           (i_Start),
        .i_Init_En         (i_Init_En),
        .i_Num_Rows        (i_Num_Rows),
        .i_Num_Passes      (i_Num_Passes),
        .i_Stall           (i_Stall),
        .o_Psram_Addr      (o_Psram_Addr),
        .o_Psram_Addr_1buf (o_Psram_Addr_1buf),
        .o_Psram_Valid_1buf(o_Psram_Valid_1buf),
        .o_Psram_En        (o_Psram_En),
        .o_Psram_Wea       (o_Psram_Wea),
        .o_Valid_WB_Psum   (o_Valid_WB_Psum),
        .o_WB_Data_Valid   (o_WB_Data_Valid),
        .o_Busy            (o_Busy),
        .o_Done            (o_Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [BA-1:0] addr;
        logic          wea;
        logic          wb;
    } iss_t;

    iss_t          en_q[$];
    logic [BA-1:0] run_q[$];
    int            wbd_pend = 0;
    int            checks = 0;
    int            errors = 0;
    int            cycle_cnt = 0;
    int            start_cycle = 0;
    int            exp_lat = -1;
    bit            job_active = 0;
    int            done_cnt = 0;
    logic          stall_prev = 1'b0;
    logic          prev_run_rd = 1'b0;
    logic          prev_wb_iss = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {o_Psram_Addr, o_Psram_Addr_1buf, o_Psram_Valid_1buf, o_Psram_En,
                o_Psram_Wea, o_Valid_WB_Psum, o_WB_Data_Valid, o_Busy, o_Done};
    endfunction

    always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

    // monitor
    always @(negedge CLK) begin
        iss_t          e;
        logic [BA-1:0] a;
        if (!RSTN) begin
            stall_prev  = 1'b0;
            prev_run_rd = 1'b0;
            prev_wb_iss = 1'b0;
        end else begin
            if (o_Psram_En != '0) begin
                chk("en_all_cols", o_Psram_En, {PC{1'b1}});
                if (en_q.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    e = en_q.pop_front();
                    chk("issue_addr", o_Psram_Addr, e.addr);
                    chk("issue_wea", o_Psram_Wea, {PC{e.wea}});
                    chk("issue_wb_flag", o_Valid_WB_Psum, e.wb);
                    if (stall_prev && !e.wea) chk("read_issued_while_stalled", 1, 0);
                end
            end else if (o_Psram_Wea != '0) begin
                chk("wea_without_en", o_Psram_Wea, 0);
            end
            if (o_Psram_Valid_1buf != '0) begin
                chk("valid1buf_all_cols", o_Psram_Valid_1buf, {PC{1'b1}});
                chk("valid1buf_follows_read", prev_run_rd, 1);
                if (run_q.size() == 0) begin
                    chk("unexpected_valid1buf", 1, 0);
                end else begin
                    a = run_q.pop_front();
                    chk("addr_1buf", o_Psram_Addr_1buf, a);
                end
            end
            if (o_WB_Data_Valid) begin
                chk("wb_dv_follows_issue", prev_wb_iss, 1);
                if (wbd_pend == 0) chk("unexpected_wb_dv", 1, 0);
                else wbd_pend--;
            end
            if (o_Done) begin
                if (!job_active) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_busy", o_Busy, 1);
                    chk("done_all_consumed", en_q.size() + run_q.size() + wbd_pend, 0);
                    if (exp_lat >= 0) chk("done_latency", cycle_cnt - start_cycle, exp_lat);
                    job_active = 0;
                end
                done_cnt++;
            end
            prev_run_rd = o_Psram_En[0] && !o_Psram_Wea[0] && !o_Valid_WB_Psum;
            prev_wb_iss = o_Psram_En[0] && o_Valid_WB_Psum;
            stall_prev  = i_Stall;
        end
    end

    // reference model: the issue stream a job must produce, independent of timing
    task automatic push_model(input int n, input int p, input bit init);
        if (n > 0 && p > 0) begin
            if (init) for (int r = 0; r < n; r++) en_q.push_back('{BA'(r), 1'b1, 1'b0});
            for (int pp = 0; pp < p; pp++)
                for (int r = 0; r < n; r++) begin
                    en_q.push_back('{BA'(r), 1'b0, 1'b0});
                    run_q.push_back(BA'(r));
                end
            for (int r = 0; r < n; r++) en_q.push_back('{BA'(r), 1'b0, 1'b1});
            wbd_pend += n;
        end
    endtask

    function automatic int base_latency(input int n, input int p, input bit init);
        if (n == 0 || p == 0) return 2;
        return 1 + (init ? n : 0) + p * n + ((n == 1) ? p - 1 : 0) + (PC + 1) + n + 1;
    endfunction

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // mode 0: no stall, 1: random stall, 2: stall on relative cycles 3 and 4
    task automatic run_job(input int n, input int p, input bit init, input int mode);
        int d0;
        int rel;
        push_model(n, p, init);
        exp_lat = (mode == 1) ? -1 : base_latency(n, p, init) + ((mode == 2) ? 2 : 0);
        @(posedge CLK);
        #1;
        chk("idle_busy_low", o_Busy, 0);
        i_Start      = 1'b1;
        i_Init_En    = init;
        i_Num_Rows   = BA'(n);
        i_Num_Passes = 8'(p);
        start_cycle  = cycle_cnt;
        job_active   = 1;
        d0 = done_cnt;
        for (int k = 0; k < 4000 && done_cnt == d0; k++) begin
            @(posedge CLK);
            #1;
            rel = cycle_cnt - start_cycle;
            i_Start = (n > 0 && p > 0 && rel == 2);
            if (i_Start) begin
                i_Num_Rows   = BA'($urandom_range(0, 255));
                i_Num_Passes = 8'($urandom_range(0, 255));
                i_Init_En    = 1'($urandom_range(0, 1));
            end
            case (mode)
                1:       i_Stall = ($urandom_range(0, 3) == 0);
                2:       i_Stall = (rel == 3 || rel == 4);
                default: i_Stall = 1'b0;
            endcase
        end
        i_Start = 1'b0;
        i_Stall = 1'b0;
        chk("job_completes", done_cnt - d0, 1);
        if (done_cnt != d0 + 1) finish_now();
    endtask

    task automatic reset_during_wb();
        int  d0;
        bit  seen;
        push_model(4, 1, 1);
        exp_lat = -1;
        @(posedge CLK);
        #1;
        i_Start = 1'b1; i_Init_En = 1'b1; i_Num_Rows = 8'd4; i_Num_Passes = 8'd1;
        start_cycle = cycle_cnt;
        job_active = 1;
        @(posedge CLK);
        #1;
        i_Start = 1'b0;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge CLK);
            seen = o_Valid_WB_Psum;
        end
        chk("reached_wb", seen, 1);
        #2;
        RSTN = 1'b0;
        en_q.delete();
        run_q.delete();
        wbd_pend = 0;
        job_active = 0;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #2;
        RSTN = 1'b1;
        d0 = done_cnt;
        repeat (8) @(posedge CLK);
        #1;
        chk("no_done_after_reset", done_cnt - d0, 0);
        chk("idle_after_reset", o_Busy, 0);
    endtask

    initial begin
        #3;
        chk("reset_outputs", all_outs(), 0);
        #19;
        RSTN = 1'b1;

        run_job(4, 1, 1, 0);
        run_job(3, 3, 0, 0);
        run_job(1, 3, 0, 0);
        run_job(1, 2, 1, 0);
        run_job(4, 1, 0, 2);
        run_job(0, 5, 1, 0);
        run_job(5, 0, 0, 0);
        reset_during_wb();
        run_job(4, 2, 1, 0);
        run_job(255, 1, 0, 1);
        for (int j = 0; j < 30; j++) begin
            run_job($urandom_range(0, 10), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), $urandom_range(0, 1));
        end
        repeat (4) @(posedge CLK);
        finish_now();
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
